// File: rtl/nqcpu_isa_pkg.sv
// Shared ISA constants for the 16-bit instruction format: primary opcodes, op kinds,
// branch conditions, ALU ops and encoder error codes.
package nqcpu_isa_pkg;

  // Primary opcodes in instr[15:12]
  localparam logic [3:0] OpcMath   = 4'h0;
  localparam logic [3:0] OpcShift  = 4'h1;
  localparam logic [3:0] OpcNotneg = 4'h2;
  localparam logic [3:0] OpcMem    = 4'h4;  // MOV, STORE and LOAD share this opcode
  localparam logic [3:0] OpcMovimm = 4'h5;
  localparam logic [3:0] OpcBranch = 4'h6;
  localparam logic [3:0] OpcJmp    = 4'h7;
  localparam logic [3:0] OpcAddpc  = 4'h8;
  localparam logic [3:0] OpcNop    = 4'hF;  // any of 9..F decodes as NOP

  typedef enum logic [3:0] {
    KindMath   = 4'd0,
    KindShift  = 4'd1,
    KindNotneg = 4'd2,
    KindMov    = 4'd3,
    KindStore  = 4'd4,
    KindLoad   = 4'd5,
    KindMovimm = 4'd6,
    KindLi16   = 4'd7,
    KindBranch = 4'd8,
    KindJmp    = 4'd9,
    KindAddpc  = 4'd10,
    KindNop    = 4'd11
  } op_kind_e;

  typedef enum logic [2:0] {
    CondEq     = 3'd0,
    CondNe     = 3'd1,
    CondLt     = 3'd2,
    CondGe     = 3'd3,
    CondGt     = 3'd4,
    CondLe     = 3'd5,
    CondRsvd   = 3'd6,
    CondAlways = 3'd7
  } br_cond_e;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluXor  = 3'd4,
    AluSlt  = 3'd5,
    AluSltu = 3'd6,
    AluMul  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ErrNone  = 2'd0,
    ErrKind  = 2'd1,
    ErrCond  = 2'd2,
    ErrRange = 2'd3
  } err_code_e;

  // True when a 16-bit immediate is representable as a signed 8-bit value
  function automatic logic imm_fits_s8(input logic [15:0] imm);
    return imm[15:8] == {8{imm[7]}};
  endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational field packer: turns one structured op into its instruction word(s)
// and classifies it as legal or not. Optional range check on signed 8-bit immediates
// is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_enc_pack
  import nqcpu_isa_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = 16'hF000
) (
  input  logic [3:0]  kind_i,
  input  logic [2:0]  sub_i,
  input  logic [2:0]  rd_i,
  input  logic [2:0]  rs1_i,
  input  logic [2:0]  rs2_i,
  input  logic [15:0] imm_i,
  output logic [15:0] word0_o,
  output logic [15:0] word1_o,
  output logic        two_words_o,
  output logic [1:0]  err_code_o
);

  logic imm_oor;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  assign imm_oor = !imm_fits_s8(imm_i);
`else
  // Without the check the low byte is encoded as-is
  assign imm_oor = 1'b0;
`endif

  // Encode the op; word1 is only meaningful for LI16 (low-byte movimm)
  always_comb begin
    word0_o     = NOP_WORD;
    word1_o     = {OpcMovimm, rd_i, 1'b0, imm_i[7:0]};
    two_words_o = 1'b0;
    err_code_o  = ErrNone;
    unique case (kind_i)
      KindMath:   word0_o = {OpcMath, rd_i, sub_i[2], rs1_i, rs2_i, sub_i[1:0]};
      KindShift:  word0_o = {OpcShift, rd_i, sub_i[2], rs1_i, rs2_i, sub_i[1:0]};
      KindNotneg: word0_o = {OpcNotneg, rd_i, sub_i[0], 3'b000, rs2_i, 2'b00};
      KindMov:    word0_o = {OpcMem, rd_i, 1'b0, rs1_i, 5'b00100};
      KindStore:  word0_o = {OpcMem, rd_i, 1'b1, rs1_i, 2'b00, sub_i[0], 2'b00};
      KindLoad:   word0_o = {OpcMem, rd_i, 1'b1, rs1_i, sub_i[1], 1'b0, sub_i[0], 2'b01};
      KindMovimm: word0_o = {OpcMovimm, rd_i, sub_i[0], imm_i[7:0]};
      KindLi16: begin
        word0_o     = {OpcMovimm, rd_i, 1'b1, imm_i[15:8]};
        two_words_o = 1'b1;
      end
      KindBranch: begin
        word0_o = {OpcBranch, sub_i, 1'b0, imm_i[7:0]};
        if (sub_i == CondRsvd) begin
          err_code_o = ErrCond;
        end else if (imm_oor) begin
          err_code_o = ErrRange;
        end
      end
      KindJmp:    word0_o = {OpcJmp, 4'b0000, rs1_i, 5'b00000};
      KindAddpc: begin
        word0_o = {OpcAddpc, rd_i, 1'b0, imm_i[7:0]};
        if (imm_oor) begin
          err_code_o = ErrRange;
        end
      end
      KindNop:    word0_o = NOP_WORD;
      default:    err_code_o = ErrKind;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Macro-op encoder: accepts structured ops over valid/ready and emits packed 16-bit
// instruction words over a second valid/ready, expanding LI16 into two movimm words.
// Build option: INSTR_ENC_RANGE_CHECK_EN rejects out-of-range BRANCH/ADDPC immediates.
module instr_encoder
  import nqcpu_isa_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_kind,
  input  logic [2:0]  op_sub,
  input  logic [2:0]  op_rd,
  input  logic [2:0]  op_rs1,
  input  logic [2:0]  op_rs2,
  input  logic [15:0] op_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic        instr_last,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {StEmpty, StLast, StFirst} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] word1_q, word1_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [15:0] pk_word0, pk_word1;
  logic        pk_two;
  logic [1:0]  pk_err;

  instr_enc_pack #(
    .NOP_WORD(NOP_WORD)
  ) u_pack (
    .kind_i     (op_kind),
    .sub_i      (op_sub),
    .rd_i       (op_rd),
    .rs1_i      (op_rs1),
    .rs2_i      (op_rs2),
    .imm_i      (op_imm),
    .word0_o    (pk_word0),
    .word1_o    (pk_word1),
    .two_words_o(pk_two),
    .err_code_o (pk_err)
  );

  // Handshake and next-state: a held final word may be replaced in the cycle it drains
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    last_d     = last_q;
    word1_d    = word1_q;
    err_d      = 1'b0;
    err_code_d = ErrNone;
    unique case (state_q)
      StEmpty: op_ready = 1'b1;
      StLast:  op_ready = instr_ready;
      StFirst: op_ready = 1'b0;
      default: op_ready = 1'b0;
    endcase

    if (state_q == StFirst) begin
      if (instr_ready) begin
        instr_d = word1_q;
        last_d  = 1'b1;
        state_d = StLast;
      end
    end else if (op_valid && op_ready) begin
      if (pk_err != ErrNone) begin
        // Rejected op consumes the slot but produces no word
        err_d      = 1'b1;
        err_code_d = pk_err;
        state_d    = StEmpty;
      end else begin
        instr_d = pk_word0;
        last_d  = !pk_two;
        word1_d = pk_word1;
        state_d = pk_two ? StFirst : StLast;
      end
    end else if (state_q == StLast && instr_ready) begin
      state_d = StEmpty;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StEmpty;
      instr_q    <= 16'h0000;
      word1_q    <= 16'h0000;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      word1_q    <= word1_d;
      last_q     <= last_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign instr_valid = (state_q != StEmpty);
  assign instr       = instr_q;
  assign instr_last  = last_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed ops with literal expectations plus a
// word-queue model checked every cycle.
module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RangeChk = 1'b1;
`else
  localparam bit RangeChk = 1'b0;
`endif
  localparam int RcEc = RangeChk ? 3 : 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op_kind = '0;
  logic [2:0]  op_sub = '0;
  logic [2:0]  op_rd = '0;
  logic [2:0]  op_rs1 = '0;
  logic [2:0]  op_rs2 = '0;
  logic [15:0] op_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr;
  logic        instr_last;
  logic        err;
  logic [1:0]  err_code;

  instr_encoder #(
    .NOP_WORD(16'hF000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_kind    (op_kind),
    .op_sub     (op_sub),
    .op_rd      (op_rd),
    .op_rs1     (op_rs1),
    .op_rs2     (op_rs2),
    .op_imm     (op_imm),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_last (instr_last),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder built from field weights; nw = number of words (0 when rejected)
  function automatic void model(input int kind, input int sub, input int rd, input int rs1,
                                input int rs2, input int imm, output int nw, output int w0,
                                output int w1, output int ec);
    int sx;
    sx = (imm >= 32768) ? imm - 65536 : imm;
    nw = 1; w0 = 0; w1 = 0; ec = 0;
    case (kind)
      0, 1: w0 = kind * 4096 + rd * 512 + (sub / 4) * 256 + rs1 * 32 + rs2 * 4 + sub % 4;
      2:    w0 = 2 * 4096 + rd * 512 + (sub % 2) * 256 + rs2 * 4;
      3:    w0 = 4 * 4096 + rd * 512 + rs1 * 32 + 4;
      4:    w0 = 4 * 4096 + rd * 512 + 256 + rs1 * 32 + (sub % 2) * 4;
      5:    w0 = 4 * 4096 + rd * 512 + 256 + rs1 * 32 + ((sub / 2) % 2) * 16 + (sub % 2) * 4 + 1;
      6:    w0 = 5 * 4096 + rd * 512 + (sub % 2) * 256 + imm % 256;
      7: begin
        nw = 2;
        w0 = 5 * 4096 + rd * 512 + 256 + imm / 256;
        w1 = 5 * 4096 + rd * 512 + imm % 256;
      end
      8: begin
        w0 = 6 * 4096 + sub * 512 + imm % 256;
        if (sub == 6) ec = 2;
        else if (RangeChk && (sx < -128 || sx > 127)) ec = 3;
      end
      9:  w0 = 7 * 4096 + rs1 * 32;
      10: begin
        w0 = 8 * 4096 + rd * 512 + imm % 256;
        if (RangeChk && (sx < -128 || sx > 127)) ec = 3;
      end
      11: w0 = 'hF000;
      default: ec = 1;
    endcase
    if (ec != 0) nw = 0;
  endfunction

  // Model state: words owed to the consumer, and an error expected next cycle
  int qw[$];
  int ql[$];
  int pend_ec = 0;
  bit prev_stall = 1'b0;
  int prev_instr = 0;
  int prev_last = 0;

  // Per-cycle compare against the queue model, sampled mid-cycle
  always @(negedge clk) begin
    int nw, w0, w1, ec;
    if (reset) begin
      qw.delete();
      ql.delete();
      pend_ec = 0;
      prev_stall = 1'b0;
      chk("mon reset valid", instr_valid, 0);
      chk("mon reset instr", instr, 0);
      chk("mon reset err", err, 0);
    end else begin
      chk("mon err", err, (pend_ec != 0) ? 1 : 0);
      chk("mon err_code", err_code, pend_ec);
      pend_ec = 0;
      chk("mon instr_valid", instr_valid, (qw.size() != 0) ? 1 : 0);
      if (qw.size() != 0 && instr_valid) begin
        chk("mon instr", instr, qw[0]);
        chk("mon instr_last", instr_last, ql[0]);
      end
      chk("mon op_ready", op_ready,
          (qw.size() == 0 || (qw.size() == 1 && instr_ready)) ? 1 : 0);
      if (prev_stall) begin
        chk("mon stable valid", instr_valid, 1);
        chk("mon stable instr", instr, prev_instr);
        chk("mon stable last", instr_last, prev_last);
      end
      prev_stall = instr_valid && !instr_ready;
      prev_instr = instr;
      prev_last = instr_last;
      if (instr_valid && instr_ready && qw.size() != 0) begin
        void'(qw.pop_front());
        void'(ql.pop_front());
      end
      if (op_valid && op_ready) begin
        model(op_kind, op_sub, op_rd, op_rs1, op_rs2, op_imm, nw, w0, w1, ec);
        if (ec != 0) begin
          pend_ec = ec;
        end else begin
          qw.push_back(w0);
          ql.push_back(nw == 1 ? 1 : 0);
          if (nw == 2) begin
            qw.push_back(w1);
            ql.push_back(1);
          end
        end
      end
    end
  end

  // Present one op until accepted; returns 1 time unit after the accepting edge
  task automatic send(input logic [3:0] k, input logic [2:0] s, input logic [2:0] d,
                      input logic [2:0] a, input logic [2:0] b, input logic [15:0] im);
    bit done;
    done = 1'b0;
    op_kind = k; op_sub = s; op_rd = d; op_rs1 = a; op_rs2 = b; op_imm = im;
    op_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (op_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    if (!done) chk("send handshake timeout", 0, 1);
  endtask

  task automatic check_now(input string name, input int valid, input int word, input int last);
    chk({name, " valid"}, instr_valid, valid);
    if (valid != 0) begin
      chk({name, " instr"}, instr, word);
      chk({name, " last"}, instr_last, last);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  k;
    logic [2:0]  s;
    logic [2:0]  d;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] im;
    int          w;
    int          ec;
  } vec_t;

  vec_t vecs[16] = '{
    '{4'd0,  3'd1, 3'd1, 3'd2, 3'd3, 16'h0000, 'h024D, 0},
    '{4'd8,  3'd1, 3'd0, 3'd0, 3'd0, 16'hFFFC, 'h62FC, 0},
    '{4'd8,  3'd1, 3'd0, 3'd0, 3'd0, 16'h0080, 'h6280, RcEc},
    '{4'd5,  3'd2, 3'd2, 3'd5, 3'd0, 16'h0000, 'h45B1, 0},
    '{4'd9,  3'd0, 3'd0, 3'd4, 3'd0, 16'h0000, 'h7080, 0},
    '{4'd13, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 'h0000, 1},
    '{4'd8,  3'd6, 3'd0, 3'd0, 3'd0, 16'h0000, 'h6C00, 2},
    '{4'd1,  3'd5, 3'd7, 3'd1, 3'd2, 16'h0000, 'h1F29, 0},
    '{4'd4,  3'd1, 3'd1, 3'd6, 3'd0, 16'h0000, 'h43C4, 0},
    '{4'd10, 3'd0, 3'd2, 3'd0, 3'd0, 16'hFF80, 'h8480, 0},
    '{4'd10, 3'd0, 3'd2, 3'd0, 3'd0, 16'h0100, 'h8400, RcEc},
    '{4'd6,  3'd1, 3'd4, 3'd0, 3'd0, 16'h1234, 'h5934, 0},
    '{4'd3,  3'd0, 3'd5, 3'd3, 3'd0, 16'h0000, 'h4A64, 0},
    '{4'd2,  3'd1, 3'd6, 3'd0, 3'd7, 16'h0000, 'h2D1C, 0},
    '{4'd11, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 'hF000, 0},
    '{4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 'h0000, 1}
  };

  initial begin
    int nw, w0, w1, ec, start;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset instr_valid", instr_valid, 0);
    chk("reset instr", instr, 0);
    chk("reset instr_last", instr_last, 0);
    chk("reset err", err, 0);
    chk("reset err_code", err_code, 0);
    chk("reset op_ready", op_ready, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    step();

    // Single-word ops and errors, back-to-back with the consumer always ready
    foreach (vecs[i]) begin
      model(vecs[i].k, vecs[i].s, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].im, nw, w0, w1, ec);
      chk($sformatf("model vec%0d err", i), ec, vecs[i].ec);
      if (ec == 0) chk($sformatf("model vec%0d word", i), w0, vecs[i].w);
      send(vecs[i].k, vecs[i].s, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].im);
      if (vecs[i].ec != 0) begin
        chk($sformatf("vec%0d err", i), err, 1);
        chk($sformatf("vec%0d err_code", i), err_code, vecs[i].ec);
        chk($sformatf("vec%0d no word", i), instr_valid, 0);
      end else begin
        check_now($sformatf("vec%0d", i), 1, vecs[i].w, 1);
        chk($sformatf("vec%0d err", i), err, 0);
      end
    end
    step();

    // LI16 expansion
    send(4'd7, 3'd0, 3'd3, 3'd0, 3'd0, 16'hBEEF);
    check_now("li16 w1", 1, 'h57BE, 0);
    chk("li16 op_ready w1", op_ready, 0);
    step();
    check_now("li16 w2", 1, 'h56EF, 1);
    step();
    chk("li16 drained", instr_valid, 0);

    // Backpressure on the first LI16 word
    instr_ready = 1'b0;
    send(4'd7, 3'd0, 3'd3, 3'd0, 3'd0, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      check_now($sformatf("bp hold%0d", i), 1, 'h57BE, 0);
      chk($sformatf("bp op_ready%0d", i), op_ready, 0);
      step();
    end
    check_now("bp hold3", 1, 'h57BE, 0);
    instr_ready = 1'b1;
    step();
    check_now("bp w2", 1, 'h56EF, 1);
    step();
    chk("bp drained", instr_valid, 0);

    // Stream of MATH ops at one word per cycle
    start = cyc;
    for (int i = 0; i < 4; i++) begin
      send(4'd0, 3'(i), 3'(i + 1), 3'(i + 2), 3'(i + 3), 16'h0000);
      model(0, i, i + 1, i + 2, i + 3, 0, nw, w0, w1, ec);
      check_now($sformatf("stream%0d", i), 1, w0, 1);
    end
    chk("stream cycles", cyc - start, 4);
    step();
    chk("stream drained", instr_valid, 0);

    // Async reset while the first LI16 word is held
    instr_ready = 1'b0;
    send(4'd7, 3'd0, 3'd1, 3'd0, 3'd0, 16'h1234);
    check_now("rst li16 w1", 1, 'h5312, 0);
    #1 reset = 1'b1;
    #1;
    chk("rst async valid", instr_valid, 0);
    chk("rst async instr", instr, 0);
    chk("rst async last", instr_last, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst no w2 %0d", i), instr_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
